cpu_port_bram_responder: RTL

CPU_PORT_BRAM_RESPONDER -- requirements
Module: cpu_port_bram_responder

---
 rtl/cpu_port_bram_responder_pkg.sv | 13 +
 rtl/cpu_port_bram.sv | 23 ++
 rtl/cpu_port_bram_responder.sv | 78 +++++++
 3 files changed

// File: rtl/cpu_port_bram_responder_pkg.sv
// cpu_port_bram_responder_pkg: shared FSM encoding and cpustate field constants
package cpu_port_bram_responder_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} fsm_t;
  localparam logic [1:0] ST_FETCH = 2'b00;
  localparam logic [1:0] ST_NONE = 2'b01;
  localparam logic [1:0] ST_READ = 2'b10;
  localparam logic [1:0] ST_WRITE = 2'b11;
  localparam int NCS_BIT = 2;
  localparam int LONG_BIT = 6;
  function automatic logic is_req(input logic [6:0] cs);
    return !cs[NCS_BIT] && cs[1:0] != ST_NONE;
  endfunction
endpackage

// File: rtl/cpu_port_bram.sv
// cpu_port_bram: single-port 16-bit RAM with byte write enables and registered read
module cpu_port_bram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);
  logic [15:0] mem [2**ADDR_W];
  // byte-lane writes; contents are never reset
  always_ff @(posedge clk) begin
    if (we[0]) mem[addr][7:0] <= wdata[7:0];
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
  end
  // read register only moves on reads so the last read value is held
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (rd) rdata <= mem[addr];
endmodule

// File: rtl/cpu_port_bram_responder.sv
// cpu_port_bram_responder: CPU bus responder with fixed access latency backed by a block RAM
module cpu_port_bram_responder
  import cpu_port_bram_responder_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int LATENCY = 3,
  parameter int ENA_DIV = 4
) (
  input  logic        clk_114,
  input  logic        reset,
  input  logic [24:1] cpuAddr,
  input  logic [6:0]  cpustate,
  input  logic        cpuL,
  input  logic        cpuU,
  input  logic [15:0] cpuWR,
  output logic [15:0] cpuRD,
  output logic        cpuena,
  output logic        enaWRreg
);
  fsm_t st, st_nx;
  logic [3:0] div_cnt, lat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0] kind_q;
  logic l_q, u_q;
  logic [15:0] wr_q;
  logic lat_done, fire, ram_rd;
  logic [1:0] ram_we;
  logic unused;
  assign unused = ^{cpustate[LONG_BIT:3], cpuAddr[24:ADDR_W+1]};
  assign lat_done = lat_cnt == 4'(LATENCY - 1);
  // free-running divider; strobe is registered one count early so it lands on the wrap
  always_ff @(posedge clk_114)
    if (reset) begin
      div_cnt <= '0;
      enaWRreg <= 1'b0;
    end else begin
      div_cnt <= div_cnt == 4'(ENA_DIV - 1) ? '0 : div_cnt + 4'd1;
      enaWRreg <= div_cnt == 4'(ENA_DIV - 2);
    end
  // state register
  always_ff @(posedge clk_114)
    st <= reset ? S_IDLE : st_nx;
  // next-state: DONE only leaves on a strobe seen while already in DONE
  always_comb
    st_nx = st == S_IDLE ? (is_req(cpustate) ? S_WAIT : S_IDLE)
          : st == S_WAIT ? (lat_done ? S_DONE : S_WAIT)
          : st == S_DONE ? (enaWRreg ? S_IDLE : S_DONE)
          : S_IDLE;
  // WAIT dwell timer
  always_ff @(posedge clk_114)
    if (reset) lat_cnt <= '0;
    else lat_cnt <= st == S_WAIT ? lat_cnt + 4'd1 : '0;
  // capture the request on acceptance; later input changes cannot disturb it
  always_ff @(posedge clk_114)
    if (st == S_IDLE && is_req(cpustate)) begin
      addr_q <= cpuAddr[ADDR_W:1];
      kind_q <= cpustate[1:0];
      l_q <= cpuL;
      u_q <= cpuU;
      wr_q <= cpuWR;
    end
  // outputs and RAM strobes; reset on the completing edge suppresses the access
  always_comb begin
    cpuena = st == S_DONE;
    fire = st == S_WAIT && lat_done && !reset;
    ram_rd = fire && !kind_q[0];
    ram_we = fire && kind_q == ST_WRITE ? {~u_q, ~l_q} : 2'b00;
  end
  cpu_port_bram #(.ADDR_W(ADDR_W)) u_ram (
    .clk(clk_114),
    .rst(reset),
    .rd(ram_rd),
    .we(ram_we),
    .addr(addr_q),
    .wdata(wr_q),
    .rdata(cpuRD)
  );
endmodule
